// File: rtl/spi_apb_master.sv
// spi_apb_master
//   APB requester for the SPI block's register port. It turns a valid/ready
//   command stream into APB SETUP/ACCESS phases and returns read data and
//   error status on a valid/ready response channel. Only one transaction is
//   in flight at a time.
//
//   Ports
//     pclk, preset                  clock (rising edge), async active-high reset
//     cmd_valid/cmd_ready           command handshake
//     cmd_write/addr/wdata/strb/prot  command fields, sampled on accept
//     rsp_valid/rsp_ready           response handshake
//     rsp_rdata/slverr/timeout      response fields, held while rsp_valid
//     paddr..pstrb, psel, penable   APB request outputs, all registered
//     pready, prdata, pslverr       APB completion inputs
//
//   Build option
//     SPI_APB_MASTER_TIMEOUT_EN  when defined, an ACCESS watchdog aborts a
//     transfer after TIMEOUT_CYCLES wait cycles (rsp_slverr = rsp_timeout = 1).
//     When undefined, ACCESS waits indefinitely and rsp_timeout stays 0.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | ready for a command; psel/penable low
//   SETUP  | command latched; psel is raised on the next edge
//   ACCESS | APB transfer in progress; waits for pready with penable high
//   RESP   | response presented until rsp_ready

module spi_apb_master #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [3:0]            cmd_strb,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [2:0]            pprot,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [3:0]            pstrb,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("spi_apb_master: TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [2:0]              pprot_q, pprot_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [3:0]              pstrb_q, pstrb_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_slverr_q, rsp_slverr_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    logic accept;
    logic xfer_done;
    logic timeout_hit;

    // APB outputs are registered and lag the state by one edge, so the
    // first ACCESS-state cycle still shows penable low on the bus. pready is
    // only honoured once penable is actually high.
    assign accept    = (state_q == S_IDLE) && cmd_ready_q && cmd_valid;
    assign xfer_done = (state_q == S_ACCESS) && penable_q && pready;

`ifdef SPI_APB_MASTER_TIMEOUT_EN
    logic [7:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == S_ACCESS) begin
            if (!penable_q) begin
                wd_cnt_d = 8'd0;
            end else if (!pready) begin
                wd_cnt_d = wd_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wd_cnt_q <= 8'd0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // Count holds the number of wait cycles already seen, so the compare
    // fires on the TIMEOUT_CYCLES-th cycle with pready low.
    assign timeout_hit = (state_q == S_ACCESS) && penable_q && !pready &&
                         (wd_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pprot_d       = pprot_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            S_IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (accept) begin
                    paddr_d  = cmd_addr;
                    pprot_d  = cmd_prot;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    pstrb_d  = cmd_write ? cmd_strb : 4'h0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b0;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                if (xfer_done) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    rsp_slverr_d  = pslverr;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RESP;
                end else if (timeout_hit) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pprot_q       <= 3'b000;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= 4'h0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pprot_q       <= pprot_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign paddr       = paddr_q;
    assign pprot       = pprot_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_spi_apb_master.sv
module tb_spi_apb_master;

    logic        pclk;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic [4:0]  paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    spi_apb_master #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Reference model: each command is turned into the APB fields the slave
    // must see, the slave's behaviour for it, and the response it must yield.
    typedef struct {
        logic [4:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } apb_exp_t;

    typedef struct {
        int          waits;
        logic [31:0] rdata;
        logic        err;
    } slv_cfg_t;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        logic        tmo;
    } rsp_exp_t;

    apb_exp_t apb_q[$];
    slv_cfg_t slv_q[$];
    rsp_exp_t rsp_q[$];

    int   checks   = 0;
    int   failures = 0;
    int   rsp_mode = 0;   // 0: ready high, 1: random, 2: ready low
    logic slave_hang = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue a command into the model queues.
    task automatic push_exp(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot, input int waits,
                            input logic [31:0] rd, input logic err);
        apb_exp_t a;
        slv_cfg_t s;
        rsp_exp_t r;
        a.addr = addr; a.wr = wr; a.wdata = wdata; a.strb = wr ? strb : 4'h0; a.prot = prot;
        s.waits = waits; s.rdata = rd; s.err = err;
        r.rdata = wr ? 32'h0 : rd; r.slverr = err; r.tmo = 1'b0;
        apb_q.push_back(a);
        slv_q.push_back(s);
        rsp_q.push_back(r);
    endtask

    task automatic drive_cmd(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic [2:0] prot);
        @(posedge pclk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        cmd_prot  = prot;
    endtask

    task automatic wait_accept(input string name);
        int n;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!cmd_ready && n < 300);
        chk(name, {63'd0, cmd_ready}, 64'd1);
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = $urandom_range(0, 1);
        cmd_addr  = 5'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_prot  = 3'($urandom);
    endtask

    task automatic send(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int waits,
                        input logic [31:0] rd, input logic err, input string name);
        push_exp(wr, addr, wdata, strb, prot, waits, rd, err);
        drive_cmd(wr, addr, wdata, strb, prot);
        wait_accept(name);
    endtask

    task automatic wait_for(input string name, input int sel);
        int n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 300) begin
            @(negedge pclk);
            n++;
            case (sel)
                0:       hit = cmd_ready;
                1:       hit = rsp_valid;
                2:       hit = penable;
                default: hit = (rsp_q.size() == 0) && !rsp_valid;
            endcase
        end
        chk(name, {63'd0, hit}, 64'd1);
    endtask

    // rsp_ready driver
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge pclk);
            #1;
            case (rsp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 2) != 0);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // APB slave model: decides pready/prdata/pslverr from the queued
    // behaviour, checks the request fields and their stability.
    initial begin
        slv_cfg_t    cur;
        logic        active;
        int          waited;
        logic [44:0] snap;
        pready  = 1'b0;
        prdata  = 32'h0;
        pslverr = 1'b0;
        active  = 1'b0;
        waited  = 0;
        snap    = '0;
        forever begin
            @(negedge pclk);
            if (preset) begin
                active = 1'b0;
                pready = 1'b0;
            end else if (psel && !penable) begin
                snap    = {paddr, pwrite, pwdata, pstrb, pprot};
                pready  = 1'($urandom);
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end else if (psel && penable) begin
                chk("apb_stable", {19'd0, paddr, pwrite, pwdata, pstrb, pprot}, {19'd0, snap});
                if (slave_hang) begin
                    pready  = 1'b0;
                    pslverr = 1'($urandom);
                    prdata  = $urandom;
                end else begin
                    if (!active) begin
                        chk("slave_cfg_present", {32'd0, 32'(slv_q.size() != 0)}, 64'd1);
                        if (slv_q.size() != 0) cur = slv_q.pop_front();
                        else begin cur.waits = 0; cur.rdata = 32'h0; cur.err = 1'b0; end
                        active = 1'b1;
                        waited = 0;
                    end
                    if (waited >= cur.waits) begin
                        apb_exp_t a;
                        chk("apb_req_present", {32'd0, 32'(apb_q.size() != 0)}, 64'd1);
                        if (apb_q.size() != 0) begin
                            a = apb_q.pop_front();
                            chk("apb_fields", {19'd0, paddr, pwrite, pwdata, pstrb, pprot},
                                {19'd0, a.addr, a.wr, a.wdata, a.strb, a.prot});
                        end
                        pready  = 1'b1;
                        prdata  = cur.rdata;
                        pslverr = cur.err;
                        active  = 1'b0;
                    end else begin
                        pready  = 1'b0;
                        pslverr = 1'($urandom);
                        prdata  = $urandom;
                        waited++;
                    end
                end
            end else begin
                pready  = 1'($urandom);
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
        end
    end

    // Response monitor / scoreboard
    initial begin
        rsp_exp_t e;
        forever begin
            @(negedge pclk);
            if (!preset && rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got rdata 0x%0h with no response expected", rsp_rdata);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                    chk("rsp_slverr", {63'd0, rsp_slverr}, {63'd0, e.slverr});
                    chk("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, e.tmo});
                end
            end
        end
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 5'h0;
        cmd_wdata = 32'h0;
        cmd_strb  = 4'h0;
        cmd_prot  = 3'h0;

        // Reset state
        repeat (3) @(negedge pclk);
        chk("reset_outputs", {54'd0, cmd_ready, psel, penable, rsp_valid, rsp_timeout, paddr},
            64'd0);
        preset = 1'b0;
        wait_for("reset_release_ready", 0);

        // Write, zero wait states: cycle-accurate latency
        rsp_mode = 0;
        push_exp(1'b1, 5'h04, 32'hA5A5_0001, 4'hF, 3'h2, 0, 32'hDEAD_BEEF, 1'b0);
        drive_cmd(1'b1, 5'h04, 32'hA5A5_0001, 4'hF, 3'h2);
        @(negedge pclk);
        chk("lat_ready_before_accept", {63'd0, cmd_ready}, 64'd1);
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        @(negedge pclk);
        chk("lat_e0_psel", {62'd0, psel, penable}, 64'd0);
        chk("lat_e0_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        @(negedge pclk);
        chk("lat_e1_psel", {62'd0, psel, penable}, 64'd2);
        @(negedge pclk);
        chk("lat_e2_penable", {62'd0, psel, penable}, 64'd3);
        chk("lat_e2_pwdata", {28'd0, pwdata, pstrb}, {28'd0, 32'hA5A5_0001, 4'hF});
        @(negedge pclk);
        chk("lat_e3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("lat_e3_psel_drop", {62'd0, psel, penable}, 64'd0);
        chk("lat_e3_rsp", {31'd0, rsp_rdata, rsp_slverr}, 64'd0);

        // Read with 3 wait states, then slave error on a read
        send(1'b0, 5'h08, 32'h0BAD_0BAD, 4'hF, 3'h0, 3, 32'h1234_5678, 1'b0, "accept_read_wait");
        send(1'b0, 5'h1C, 32'h0, 4'h3, 3'h5, 1, 32'hCAFE_F00D, 1'b1, "accept_read_err");
        wait_for("drain_directed", 3);

        // Backpressure: response held, new command ignored
        rsp_mode = 2;
        send(1'b0, 5'h10, 32'h0, 4'h0, 3'h1, 2, 32'h5A5A_C3C3, 1'b0, "accept_bp");
        wait_for("bp_rsp_valid", 1);
        push_exp(1'b1, 5'h0C, 32'h7777_0000, 4'h5, 3'h3, 0, 32'h0, 1'b0);
        drive_cmd(1'b1, 5'h0C, 32'h7777_0000, 4'h5, 3'h3);
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            chk("bp_rsp_held", {30'd0, rsp_valid, rsp_rdata, rsp_slverr},
                {30'd0, 1'b1, 32'h5A5A_C3C3, 1'b0});
            chk("bp_no_accept", {62'd0, cmd_ready, psel}, 64'd0);
        end
        rsp_mode = 0;
        wait_accept("bp_next_accept");
        wait_for("drain_bp", 3);

        // Reset in the middle of ACCESS
        slave_hang = 1'b1;
        drive_cmd(1'b0, 5'h14, 32'h0, 4'h0, 3'h0);
        wait_accept("accept_rst_mid");
        wait_for("rst_mid_penable", 2);
        #2 preset = 1'b1;
        #1;
        chk("rst_mid_async", {60'd0, psel, penable, rsp_valid, cmd_ready}, 64'd0);
        @(negedge pclk);
        preset     = 1'b0;
        slave_hang = 1'b0;
        wait_for("rst_mid_ready_after", 0);

`ifdef SPI_APB_MASTER_TIMEOUT_EN
        begin
            rsp_exp_t r;
            int n;
            r.rdata = 32'h0; r.slverr = 1'b1; r.tmo = 1'b1;
            rsp_q.push_back(r);
            slave_hang = 1'b1;
            drive_cmd(1'b0, 5'h18, 32'h0, 4'h0, 3'h0);
            wait_accept("accept_timeout");
            n = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge pclk);
                if (penable) n++;
                else if (n > 0 && !psel) break;
            end
            chk("timeout_access_cycles", 64'(n), 64'd16);
            slave_hang = 1'b0;
            wait_for("drain_timeout", 3);
        end
`else
        slave_hang = 1'b1;
        drive_cmd(1'b0, 5'h18, 32'h0, 4'h0, 3'h0);
        wait_accept("accept_no_timeout");
        repeat (40) @(negedge pclk);
        chk("no_timeout_held", {61'd0, psel, penable, rsp_valid}, 64'd6);
        #2 preset = 1'b1;
        @(negedge pclk);
        preset     = 1'b0;
        slave_hang = 1'b0;
        wait_for("no_timeout_recover", 0);
`endif

        // Randomized traffic with random response backpressure
        rsp_mode = 1;
        for (int i = 0; i < 40; i++) begin
            logic        wr;
            logic [31:0] wd;
            logic [31:0] rd;
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            rd = $urandom;
            repeat ($urandom_range(0, 2)) @(posedge pclk);
            send(wr, 5'($urandom), wd, 4'($urandom), 3'($urandom), $urandom_range(0, 4), rd,
                 ($urandom_range(0, 3) == 0), "accept_rand");
        end
        rsp_mode = 0;
        wait_for("drain_rand", 3);
        chk("queues_empty", 64'(apb_q.size() + slv_q.size() + rsp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_apb_master.md
Name: spi_apb_master

Overview:
- APB requester that drives the SPI block's APB slave port: register accesses to control, baud-rate and interrupt registers, TX FIFO writes and RX FIFO reads.
- Turns a simple valid/ready command stream (from a CPU bridge or test sequencer) into APB SETUP/ACCESS phases.
- Returns read data and error status on a valid/ready response channel.
- Single outstanding transaction; sits between the system interconnect and the SPI APB slave.

Parameters:
- ADDR_WIDTH, 5, width of paddr/cmd_addr; matches the SPI register map.
- DATA_WIDTH, 32, width of pwdata/prdata/cmd_wdata/rsp_rdata.
- TIMEOUT_CYCLES, 16, ACCESS-phase cycles before abort; used only with the optional feature; legal range 1..255.

Ports:
- pclk  in  1  single clock, rising edge.
- preset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target register address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  4  byte strobes for writes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_slverr  out  1  transfer ended with an error.
- rsp_timeout  out  1  transfer aborted by the watchdog.
- paddr  out  ADDR_WIDTH  APB address.
- pprot  out  3  APB protection.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  4  APB strobes.
- pready  in  1  slave ready.
- prdata  in  DATA_WIDTH  slave read data.
- pslverr  in  1  slave error.

Behaviour:
- Reset: asynchronous on preset high. All outputs are 0 and the FSM goes to IDLE immediately, including mid-transfer. No response is produced for an interrupted transfer.
- All APB and response outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1; psel = 0; penable = 0.
  - On accept, register addr/wdata/write/prot. pstrb = cmd_strb for writes and 4'h0 for reads.
  - Next state: SETUP.
- SETUP: psel = 1, penable = 0, exactly one cycle; next state ACCESS.
- ACCESS:
  - psel = 1, penable = 1.
  - Wait while pready = 0. paddr, pwrite, pwdata, pstrb and pprot are held stable for the whole transfer.
  - On pready = 1: capture pslverr, and capture prdata for reads only (writes return 0). Drop psel/penable on the next edge and go to RESP.
- RESP:
  - rsp_valid = 1; rsp fields held stable until rsp_ready.
  - cmd_ready = 0; no new command is accepted until the FSM returns to IDLE.
  - On rsp_valid & rsp_ready: rsp_valid = 0, next state IDLE.
- Latency, zero wait states:
  - Accept at edge 0; psel high after edge 1; penable high after edge 2.
  - pready sampled high at edge 3; rsp_valid high after edge 3.
  - Minimum issue interval is 5 cycles per transaction, with rsp_ready tied high.
- Between transfers: paddr, pwdata and pwrite keep their last values; psel and penable are 0.
- pslverr is ignored unless sampled with pready = 1 in ACCESS.
- cmd_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: SPI_APB_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with pready = 0.
  - When the count reaches TIMEOUT_CYCLES with pready still 0: drop psel/penable on the next edge and enter RESP with rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0.
  - If pready = 1 in the same cycle the count is reached, it is a normal completion (pready wins).
- Undefined: no counter exists, ACCESS waits indefinitely, and rsp_timeout is tied to 0.

Test Plan:
- Write, zero wait: cmd addr 0x04, wdata 0xA5A5_0001, strb 0xF; pready held 1 -> psel rises cycle 1, penable cycle 2; pwdata 0xA5A5_0001, pstrb 0xF; rsp_valid cycle 3 with slverr 0 and rdata 0.
- Read, 3 wait states: addr 0x08, slave raises pready on the 4th ACCESS cycle with prdata 0x1234_5678 -> rsp_rdata 0x1234_5678; pstrb 0x0; paddr stable at 0x08 for all SETUP/ACCESS cycles.
- Slave error: read addr 0x1C, pslverr = 1 with pready -> rsp_slverr = 1, rsp_timeout = 0, rsp_rdata = prdata.
- Backpressure: rsp_ready low for 5 cycles with cmd_valid high -> rsp_valid and fields held, cmd_ready = 0, psel stays 0; after rsp_ready, IDLE, then the next command is accepted.
- Reset mid-ACCESS: assert preset while penable = 1 -> psel, penable and rsp_valid go 0 without a clock edge; after release, cmd_ready = 1.
- Timeout (macro defined, TIMEOUT_CYCLES = 16): pready stuck 0 -> psel drops after 16 ACCESS cycles, rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0. Without the macro, psel remains high.
